// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states, data width
// and a frame-length helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  // Clock cycles occupied by one frame on the line.
  function automatic int frame_cycles(input int div, input logic par_en, input logic two_stop);
    return (div + 1) * (10 + int'(par_en) + int'(two_stop));
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
interface uart_tx_buffered_if
  import uart_pkg::*;
;
  logic                      tx_valid;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head output that always holds the oldest
// entry while the FIFO is non-empty.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
  logic             do_push, do_pop;

  assign full        = (level == FULL_LEVEL);
  assign empty       = (level == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rd_ptr_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // A write landing on the next head slot is forwarded so the head register never goes stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_ptr_next;
      rd_data <= (do_push && (wr_ptr == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, LSB-first framing with optional parity
// and one or two stop bits at a runtime-programmable bit period.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic                   two_stop,
  uart_tx_buffered_if.slave      bus,
  output logic                   TxD,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state, state_next;
  logic [DIV_W-1:0]          timer, timer_next, div_q, div_next;
  logic                      par_en_q, par_en_next, par_odd_q, par_odd_next;
  logic                      two_stop_q, two_stop_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next, head;
  logic [2:0]                bit_cnt, bit_cnt_next;
  logic                      parity, parity_next;
  logic                      tx_bit, load, timer_done, full, empty;

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.tx_valid),
    .pop     (load),
    .wr_data (bus.tx_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign bus.tx_ready = !full;
  assign tx_busy      = (state != IDLE) || !empty;
  assign timer_done   = (timer == '0);

  always_comb begin
    state_next    = state;
    timer_next    = timer_done ? timer : timer - 1'b1;
    div_next      = div_q;
    par_en_next   = par_en_q;
    par_odd_next  = par_odd_q;
    two_stop_next = two_stop_q;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    parity_next   = parity;
    tx_bit        = 1'b1;
    load          = 1'b0;

    case (state)
      IDLE: begin
        load = !empty;
        if (!empty) state_next = START;
      end
      START: begin
        tx_bit = 1'b0;
        if (timer_done) begin
          state_next = DATA;
          timer_next = div_q;
        end
      end
      DATA: begin
        tx_bit = shift[0];
        if (timer_done) begin
          shift_next   = shift >> 1;
          parity_next  = parity ^ shift[0];
          bit_cnt_next = bit_cnt + 1'b1;
          timer_next   = div_q;
          if (bit_cnt == LAST_BIT) state_next = par_en_q ? PARITY : STOP1;
        end
      end
      PARITY: begin
        tx_bit = parity ^ par_odd_q;
        if (timer_done) begin
          state_next = STOP1;
          timer_next = div_q;
        end
      end
      STOP1: begin
        if (timer_done) begin
          if (two_stop_q) begin
            state_next = STOP2;
            timer_next = div_q;
          end else begin
            load       = !empty;
            state_next = empty ? IDLE : START;
          end
        end
      end
      STOP2: begin
        if (timer_done) begin
          load       = !empty;
          state_next = empty ? IDLE : START;
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame start: configuration is captured here and held for the whole frame.
    if (load) begin
      shift_next    = head;
      div_next      = baud_div;
      par_en_next   = parity_en;
      par_odd_next  = parity_odd;
      two_stop_next = two_stop;
      parity_next   = 1'b0;
      bit_cnt_next  = '0;
      timer_next    = baud_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      parity     <= 1'b0;
      TxD        <= 1'b1;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      div_q      <= div_next;
      par_en_q   <= par_en_next;
      par_odd_q  <= par_odd_next;
      two_stop_q <= two_stop_next;
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      parity     <= parity_next;
      TxD        <= tx_bit;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: frame vectors from a table plus
// hand-written sequences for FIFO-full, back-to-back, reset and loopback.
module tb_uart_tx_buffered;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DIV_W-1:0]       baud_div;
  logic                   parity_en, parity_odd, two_stop;
  logic                   TxD, tx_busy;
  logic [$clog2(DEPTH):0] fifo_level;
  int                     checks = 0;
  int                     errors = 0;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .bus        (bus),
    .TxD        (TxD),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       par_en;
    logic       par_odd;
    logic       two;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] sent_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    bus.tx_valid = 1'b1;
    bus.tx_data  = data;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic resetDut(input string tag);
    rst = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_txd"}, TxD, 1);
    checkOutput({tag, "_ready"}, bus.tx_ready, 1);
    checkOutput({tag, "_busy"}, tx_busy, 0);
    checkOutput({tag, "_level"}, fifo_level, 0);
    rst = 1'b0;
  endtask

  // Push one byte into an idle transmitter and check every cycle of its frame.
  task automatic runFrame(input int idx, input vec_t v, input int alt_div);
    logic [11:0] bits;
    int          nbits;
    logic        bitval;
    int          b, cyc;
    baud_div   = DIV_W'(v.div);
    parity_en  = v.par_en;
    parity_odd = v.par_odd;
    two_stop   = v.two;
    bits       = '1;
    bits[0]    = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = v.data[i];
    nbits = 9;
    if (v.par_en) begin
      bits[nbits] = v.exp_par;
      nbits++;
    end
    applyStimulus(v.data);
    checkOutput($sformatf("vec%0d_level_push", idx), fifo_level, 1);
    checkOutput($sformatf("vec%0d_busy_push", idx), tx_busy, 1);
    @(negedge clk);
    checkOutput($sformatf("vec%0d_txd_latency", idx), TxD, 1);
    checkOutput($sformatf("vec%0d_level_pop", idx), fifo_level, 0);
    bitval = 1'b1;
    for (int k = 0; k < v.exp_len; k++) begin
      @(negedge clk);
      if (k == 3 && alt_div >= 0) baud_div = DIV_W'(alt_div);
      b   = k / (v.div + 1);
      cyc = k % (v.div + 1);
      if (cyc == 0) bitval = bits[b];
      if (TxD !== bits[b]) bitval = TxD;
      if (cyc == v.div) checkOutput($sformatf("vec%0d_bit%0d", idx, b), bitval, bits[b]);
      if (k == v.exp_len - 2) checkOutput($sformatf("vec%0d_busy_end", idx), tx_busy, 1);
      if (k == v.exp_len - 1) checkOutput($sformatf("vec%0d_busy_idle", idx), tx_busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [29:0] stream_got, stream_exp;
    logic [7:0]  b2b[3];
    int          accepted;

    //          data   div par odd two par len
    vecs[0] = '{8'h55, 3, 0, 0, 0, 0, 40};
    vecs[1] = '{8'hA5, 3, 1, 0, 0, 0, 44};
    vecs[2] = '{8'hA5, 3, 1, 1, 1, 1, 48};
    vecs[3] = '{8'h00, 0, 0, 0, 0, 0, 10};
    vecs[4] = '{8'hFF, 1, 1, 1, 0, 1, 22};
    vecs[5] = '{8'h01, 2, 1, 0, 1, 1, 36};
    vecs[6] = '{8'h80, 5, 0, 0, 1, 0, 66};

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    baud_div     = DIV_W'(3);
    parity_en    = 1'b0;
    parity_odd   = 1'b0;
    two_stop     = 1'b0;
    @(negedge clk);
    resetDut("reset");

    for (int i = 0; i < 7; i++) runFrame(i, vecs[i], -1);

    // Divisor changed mid-frame must not stretch the current frame; next frame uses it.
    runFrame(10, vecs[0], 0);
    runFrame(11, vecs[3], -1);

    // Back-to-back frames at one cycle per bit.
    baud_div = '0; parity_en = 1'b0; two_stop = 1'b0;
    b2b[0] = 8'hA5; b2b[1] = 8'h3C; b2b[2] = 8'h96;
    for (int j = 0; j < 3; j++) applyStimulus(b2b[j]);
    checkOutput("b2b_level", fifo_level, 2);
    for (int j = 0; j < 3; j++) begin
      stream_exp[10*j] = 1'b0;
      for (int i = 0; i < 8; i++) stream_exp[10*j+i+1] = b2b[j][i];
      stream_exp[10*j+9] = 1'b1;
    end
    for (int k = 0; k < 30; k++) begin
      if (k != 0) @(negedge clk);
      stream_got[k] = TxD;
    end
    checkOutput("b2b_stream", stream_got, stream_exp);
    checkOutput("b2b_busy_idle", tx_busy, 0);

    // Fill the FIFO behind a slow frame.
    baud_div = DIV_W'(100);
    accepted = 0;
    for (int i = 0; i < 18; i++) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'(i);
      if (bus.tx_ready) accepted++;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    checkOutput("full_accepted", accepted, 17);
    checkOutput("full_level", fifo_level, 16);
    checkOutput("full_ready", bus.tx_ready, 0);
    resetDut("flush");

    // Reset in the middle of the data bits.
    baud_div = DIV_W'(3);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    repeat (8) @(negedge clk);
    checkOutput("middata_txd", TxD, 0);
    checkOutput("middata_level", fifo_level, 1);
    resetDut("middata_rst");
    runFrame(20, vecs[0], -1);

    // Loopback through a bench-side 8N1 receiver.
    baud_div = DIV_W'(3); parity_en = 1'b0; two_stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          logic [7:0] byte_v;
          int w;
          w = 0;
          while (!bus.tx_ready && w < 2000) begin
            @(negedge clk);
            w++;
          end
          if (!bus.tx_ready) begin
            checkOutput("loop_ready_timeout", 0, 1);
            break;
          end
          byte_v = 8'($urandom_range(0, 255));
          sent_q.push_back(byte_v);
          applyStimulus(byte_v);
        end
      end
      begin
        for (int i = 0; i < 256; i++) begin
          logic [7:0] d, exp_b;
          logic       st, sp;
          int         w;
          w = 0;
          while (TxD !== 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
          end
          if (TxD !== 1'b0) begin
            checkOutput("loop_start_timeout", 1, 0);
            break;
          end
          repeat (2) @(negedge clk);
          st = TxD;
          for (int b = 0; b < 8; b++) begin
            repeat (4) @(negedge clk);
            d[b] = TxD;
          end
          repeat (4) @(negedge clk);
          sp    = TxD;
          exp_b = (sent_q.size() != 0) ? sent_q.pop_front() : 8'hxx;
          checkOutput($sformatf("loop_byte%0d", i), {22'd0, st, sp, d}, {22'd0, 1'b0, 1'b1, exp_b});
        end
      end
    join

    for (int w = 0; w < 200 && tx_busy; w++) @(negedge clk);
    checkOutput("final_idle", tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
